// File: rtl/shift_register_universal.sv
// Universal shift register: hold/shift/rotate/load/clear modes plus an
// autonomous burst engine that loads once and shifts WIDTH bits out LSB-first.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | register follows mode; burst_start loads pl_data and arms a burst
// S_SHIFT | burst in progress, one right shift per non-inhibited edge
// S_DONE  | one-cycle completion marker, then back to S_IDLE
module shift_register_universal #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_,
    input  logic             clock_inhibit,
    input  logic [2:0]       mode,
    input  logic             ds_right,
    input  logic             ds_left,
    input  logic [WIDTH-1:0] pl_data,
    input  logic             burst_start,
    output logic [WIDTH-1:0] registrador,
    output logic             q_ser,
    output logic             q_ser_n,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bit_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [2:0] M_HOLD  = 3'd0;
    localparam logic [2:0] M_SHR   = 3'd1;
    localparam logic [2:0] M_SHL   = 3'd2;
    localparam logic [2:0] M_LOAD  = 3'd3;
    localparam logic [2:0] M_ROR   = 3'd4;
    localparam logic [2:0] M_ROL   = 3'd5;
    localparam logic [2:0] M_ASR   = 3'd6;
    localparam logic [2:0] M_CLEAR = 3'd7;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q, reg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state, register and counter; an inhibited edge keeps everything as is.
    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        if (!clock_inhibit) begin
            case (state_q)
                S_IDLE: begin
                    if (burst_start) begin
                        reg_d   = pl_data;
                        cnt_d   = CNT_FULL;
                        state_d = S_SHIFT;
                    end else begin
                        case (mode)
                            M_HOLD:  reg_d = reg_q;
                            M_SHR:   reg_d = {ds_right, reg_q[WIDTH-1:1]};
                            M_SHL:   reg_d = {reg_q[WIDTH-2:0], ds_left};
                            M_LOAD:  reg_d = pl_data;
                            M_ROR:   reg_d = {reg_q[0], reg_q[WIDTH-1:1]};
                            M_ROL:   reg_d = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
                            M_ASR:   reg_d = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
                            M_CLEAR: reg_d = '0;
                            default: reg_d = reg_q;
                        endcase
                    end
                end
                S_SHIFT: begin
                    reg_d = {ds_right, reg_q[WIDTH-1:1]};
                    cnt_d = cnt_q - CNT_ONE;
                    // Last bit leaves on this edge; the counter lands on zero.
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, register and counter flops with asynchronous clear.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= S_IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from the flops, so they are glitch-free.
    always_comb begin
        registrador = reg_q;
        q_ser       = reg_q[0];
        q_ser_n     = ~reg_q[0];
        busy        = (state_q == S_SHIFT);
        done        = (state_q == S_DONE);
        bit_count   = cnt_q;
    end

endmodule

// File: tb/tb_shift_register_universal.sv
// Bench for shift_register_universal (WIDTH=8): directed vectors, expected
// values queued by the stimulus and checked by an independent monitor.
module tb_shift_register_universal;

    logic       clock = 1'b0;
    logic       reset_;
    logic       clock_inhibit;
    logic [2:0] mode;
    logic       ds_right;
    logic       ds_left;
    logic [7:0] pl_data;
    logic       burst_start;
    logic [7:0] registrador;
    logic       q_ser;
    logic       q_ser_n;
    logic       busy;
    logic       done;
    logic [3:0] bit_count;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        string      nm;
        logic [7:0] r;
        logic       b;
        logic       d;
        logic [3:0] bc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    shift_register_universal #(.WIDTH(8)) dut (
        .clock         (clock),
        .reset_        (reset_),
        .clock_inhibit (clock_inhibit),
        .mode          (mode),
        .ds_right      (ds_right),
        .ds_left       (ds_left),
        .pl_data       (pl_data),
        .burst_start   (burst_start),
        .registrador   (registrador),
        .q_ser         (q_ser),
        .q_ser_n       (q_ser_n),
        .busy          (busy),
        .done          (done),
        .bit_count     (bit_count)
    );

    always #5 clock = ~clock;

    task automatic check(input exp_t e);
        n_chk++;
        if (registrador !== e.r || q_ser !== e.r[0] || q_ser_n !== ~e.r[0] ||
            busy !== e.b || done !== e.d || bit_count !== e.bc) begin
            n_fail++;
            $display("FAIL %s: got reg=%h qs=%b qsn=%b busy=%b done=%b cnt=%0d, expected reg=%h qs=%b qsn=%b busy=%b done=%b cnt=%0d",
                     e.nm, registrador, q_ser, q_ser_n, busy, done, bit_count,
                     e.r, e.r[0], ~e.r[0], e.b, e.d, e.bc);
        end
    endtask

    // Monitor: every falling edge, compare the DUT against the oldest expectation.
    always @(negedge clock) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check(mon_e);
        end
    end

    task automatic push(input string nm, input logic [7:0] r, input logic b,
                        input logic d, input logic [3:0] bc);
        exp_t e;
        e.nm = nm; e.r = r; e.b = b; e.d = d; e.bc = bc;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Burst with optional inhibit window and an ignored-input poke at cycle poke_c.
    task automatic burst(input string nm, input logic [7:0] pl, input logic ds,
                         input int inh_start, input int inh_len, input int poke_c);
        logic [15:0] w;
        int k;
        int c;
        logic inh;
        w = {(ds ? 8'hFF : 8'h00), pl};
        pl_data = pl; ds_right = ds; mode = 3'd0; burst_start = 1'b1; clock_inhibit = 1'b0;
        tick();
        k = 0; c = 1;
        push(nm, w[0 +: 8], 1'b1, 1'b0, 4'd8);
        while (k < 8) begin
            inh = (c >= inh_start) && (c < inh_start + inh_len);
            clock_inhibit = inh;
            if (c == poke_c) begin
                burst_start = 1'b1; mode = 3'd7; pl_data = ~pl;
            end else begin
                burst_start = 1'b0; mode = 3'd0; pl_data = pl;
            end
            tick();
            c++;
            if (!inh) k++;
            if (k < 8) push(nm, w[k +: 8], 1'b1, 1'b0, 4'(8 - k));
            else       push({nm, "_done"}, w[8 +: 8], 1'b0, 1'b1, 4'd0);
        end
        clock_inhibit = 1'b0; burst_start = 1'b0; mode = 3'd0; pl_data = pl;
        tick();
        push({nm, "_idle"}, w[8 +: 8], 1'b0, 1'b0, 4'd0);
    endtask

    logic [2:0] mt [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [7:0] me [8] = '{8'h96, 8'hCB, 8'h2C, 8'h3C, 8'h4B, 8'h2D, 8'hCB, 8'h00};
    string      mn [8] = '{"hold", "shr", "shl", "load", "ror", "rol", "asr", "clear"};

    initial begin
        exp_t e;
        int guard;
        reset_ = 1'b0; clock_inhibit = 1'b0; mode = 3'd0; ds_right = 1'b0;
        ds_left = 1'b0; pl_data = 8'h00; burst_start = 1'b0;
        tick();
        push("reset_init", 8'h00, 1'b0, 1'b0, 4'd0);
        reset_ = 1'b1;

        // Mode table on 1001_0110 with ds_right=1, ds_left=0
        ds_right = 1'b1; ds_left = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mode = 3'd3; pl_data = 8'h96;
            tick();
            push("preload", 8'h96, 1'b0, 1'b0, 4'd0);
            mode = mt[i]; pl_data = 8'h3C;
            tick();
            push(mn[i], me[i], 1'b0, 1'b0, 4'd0);
        end

        // Plain burst, ds_right=1 so vacated bits fill with ones
        burst("burst_b4", 8'hB4, 1'b1, 0, 0, 0);
        // Inhibit for 3 cycles starting at T+4
        burst("burst_inh", 8'h5A, 1'b0, 4, 3, 0);
        // burst_start and CLEAR poked at T+3 must be ignored
        burst("burst_poke", 8'hB4, 1'b0, 0, 0, 3);

        // Back-to-back: burst_start held high, new load every W+2 cycles
        mode = 3'd0; ds_right = 1'b0; pl_data = 8'hC3; burst_start = 1'b1;
        for (int p = 0; p < 2; p++) begin
            logic [15:0] w;
            w = {8'h00, 8'hC3};
            for (int k = 0; k < 8; k++) begin
                tick();
                push("b2b_shift", w[k +: 8], 1'b1, 1'b0, 4'(8 - k));
            end
            tick();
            push("b2b_done", 8'h00, 1'b0, 1'b1, 4'd0);
            tick();
            push("b2b_idle", 8'h00, 1'b0, 1'b0, 4'd0);
        end
        tick();
        push("b2b_reload", 8'hC3, 1'b1, 1'b0, 4'd8);
        burst_start = 1'b0;
        repeat (10) tick();

        // Async reset mid-burst with registrador=A5
        pl_data = 8'hA5; burst_start = 1'b1;
        tick();
        push("rst_pre", 8'hA5, 1'b1, 1'b0, 4'd8);
        burst_start = 1'b0;
        @(negedge clock);
        #1;
        reset_ = 1'b0;
        #1;
        e.nm = "reset_async"; e.r = 8'h00; e.b = 1'b0; e.d = 1'b0; e.bc = 4'd0;
        check(e);
        tick();
        reset_ = 1'b1;
        tick();
        push("rst_release", 8'h00, 1'b0, 1'b0, 4'd0);
        mode = 3'd3; pl_data = 8'hA5;
        tick();
        push("rst_idle_load", 8'hA5, 1'b0, 1'b0, 4'd0);
        mode = 3'd0;

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            tick();
            guard++;
        end
        if (sb.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
